// File: rtl/fetch_unit.sv
// IF-stage fetch engine: in-order imem requests, prefetch queue, stall/redirect.
// Optional FETCH_PERF_EN adds perf_bubble_cnt_o (unstalled bubble cycles).
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stall_IF,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_IF,
   output logic [31:0] pc_IF,
   output logic        fetch_bubble_o
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_bubble_cnt_o
`endif
);

   localparam int unsigned AW = $clog2(QDEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0] QLIM = (CW+1)'(QDEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] q_cnt_q, q_cnt_d;
   logic [AW-1:0] q_rd_q, q_rd_d;
   logic [AW-1:0] q_wr_q, q_wr_d;
   logic [AW-1:0] t_rd_q, t_rd_d;
   logic [AW-1:0] t_wr_q, t_wr_d;
   logic [31:0]   tag_q [QDEPTH];
   logic [31:0]   tag_d [QDEPTH];
   logic [31:0]   q_instr_q [QDEPTH];
   logic [31:0]   q_instr_d [QDEPTH];
   logic [31:0]   q_pc_q [QDEPTH];
   logic [31:0]   q_pc_d [QDEPTH];

   logic          issue, resp, push, pop;
   logic [CW:0]   busy;
   logic          unused_pc_lsb;

   assign unused_pc_lsb = ^redirect_pc_i[1:0];

   // outstanding counts every in-flight word, including ones to be dropped
   assign busy = {1'b0, q_cnt_q} + {1'b0, outst_q};
   assign imem_req_o = rst_ni & ~redirect_i & (busy < QLIM);
   assign imem_addr_o = fetch_pc_q;
   assign issue = imem_req_o & imem_gnt_i;
   assign resp = imem_rvalid_i;
   assign push = resp & (drop_q == '0) & ~redirect_i;
   assign pop = ~stall_IF & (q_cnt_q != '0) & ~redirect_i;

   assign fetch_bubble_o = (q_cnt_q == '0);
   assign instr_IF = fetch_bubble_o ? 32'h0000_0013 : q_instr_q[q_rd_q];
   assign pc_IF = fetch_bubble_o ? 32'h0 : q_pc_q[q_rd_q];

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      outst_d = outst_q;
      drop_d = drop_q;
      q_cnt_d = q_cnt_q;
      q_rd_d = q_rd_q;
      q_wr_d = q_wr_q;
      t_rd_d = t_rd_q;
      t_wr_d = t_wr_q;
      tag_d = tag_q;
      q_instr_d = q_instr_q;
      q_pc_d = q_pc_q;
      if (issue) begin
         tag_d[t_wr_q] = fetch_pc_q;
         t_wr_d = t_wr_q + AW'(1);
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (resp) t_rd_d = t_rd_q + AW'(1);
      outst_d = outst_q + CW'(issue) - CW'(resp);
      if (resp && drop_q != '0) drop_d = drop_q - CW'(1);
      if (push) begin
         q_instr_d[q_wr_q] = imem_rdata_i;
         q_pc_d[q_wr_q] = tag_q[t_rd_q];
         q_wr_d = q_wr_q + AW'(1);
      end
      if (pop) q_rd_d = q_rd_q + AW'(1);
      q_cnt_d = q_cnt_q + CW'(push) - CW'(pop);
      if (redirect_i) begin
         fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
         q_cnt_d = '0;
         q_rd_d = '0;
         q_wr_d = '0;
         drop_d = outst_q - CW'(resp);
         outst_d = outst_q - CW'(resp);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_pc_q <= RESET_PC;
         outst_q <= '0;
         drop_q <= '0;
         q_cnt_q <= '0;
         q_rd_q <= '0;
         q_wr_q <= '0;
         t_rd_q <= '0;
         t_wr_q <= '0;
         tag_q <= '{default: '0};
         q_instr_q <= '{default: '0};
         q_pc_q <= '{default: '0};
      end else begin
         fetch_pc_q <= fetch_pc_d;
         outst_q <= outst_d;
         drop_q <= drop_d;
         q_cnt_q <= q_cnt_d;
         q_rd_q <= q_rd_d;
         q_wr_q <= q_wr_d;
         t_rd_q <= t_rd_d;
         t_wr_q <= t_wr_d;
         tag_q <= tag_d;
         q_instr_q <= q_instr_d;
         q_pc_q <= q_pc_d;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (fetch_bubble_o && !stall_IF && !redirect_i && perf_q != '1)
         perf_d = perf_q + 32'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) perf_q <= '0;
      else perf_q <= perf_d;
   end

   assign perf_bubble_cnt_o = perf_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model, in-order memory model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_unit;

   localparam int QD = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, redirect, gnt, rvalid;
   logic [31:0] rpc, rdata;
   logic        req, bub;
   logic [31:0] addr, instr, pc;
   logic [31:0] perf;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .stall_IF(stall),
      .redirect_i(redirect),
      .redirect_pc_i(rpc),
      .imem_req_o(req),
      .imem_addr_o(addr),
      .imem_gnt_i(gnt),
      .imem_rvalid_i(rvalid),
      .imem_rdata_i(rdata),
      .instr_IF(instr),
      .pc_IF(pc),
      .fetch_bubble_o(bub)
`ifdef FETCH_PERF_EN
      ,
      .perf_bubble_cnt_o(perf)
`endif
   );

`ifndef FETCH_PERF_EN
   assign perf = 32'h0;
`endif

   typedef struct {
      logic [31:0] data;
      int rdy;
   } mem_t;
   typedef struct {
      logic [31:0] pc;
      bit doomed;
   } fl_t;
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } pq_t;

   mem_t mem[$];
   fl_t infl[$];
   pq_t pq[$];

   logic [31:0] m_pc;
   longint      m_perf;
   int          cyc_n = 0;
   int          checks = 0;
   int          errors = 0;
   bit          fix_data = 1'b0;
   int          lat_max = 0;
   logic        s_req, s_bub;
   logic [31:0] s_addr, s_instr, s_pc;

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %h want %h @cyc %0d", n, a, e, cyc_n);
      end
   endtask

   task automatic model_reset();
      mem.delete();
      infl.delete();
      pq.delete();
      m_pc = 32'h0;
      m_perf = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      stall = 1'b0;
      redirect = 1'b0;
      rpc = 32'h0;
      gnt = 1'b0;
      rvalid = 1'b0;
      rdata = 32'h0;
      model_reset();
      #1;
      chk("rst_req", {31'b0, req}, 32'd0);
      chk("rst_addr", addr, 32'h0);
      chk("rst_instr", instr, 32'h13);
      chk("rst_pc", pc, 32'h0);
      chk("rst_bub", {31'b0, bub}, 32'd1);
`ifdef FETCH_PERF_EN
      chk("rst_perf", perf, 32'h0);
`endif
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic cyc(input bit st, input bit rd,
                      input logic [31:0] rp,
                      input bit g, input bit ra);
      logic        e_req, e_bub;
      logic [31:0] e_instr, e_pc;
      bit          empty0;
      fl_t         f;
      @(negedge clk);
      stall = st;
      redirect = rd;
      rpc = rp;
      gnt = g;
      rvalid = ra && mem.size() > 0 && mem[0].rdy <= cyc_n;
      rdata = rvalid ? mem[0].data : $urandom;
      e_req = !rd && (pq.size() + infl.size() < QD);
      e_bub = (pq.size() == 0);
      e_instr = e_bub ? 32'h13 : pq[0].instr;
      e_pc = e_bub ? 32'h0 : pq[0].pc;
      #1;
      s_req = req;
      s_bub = bub;
      s_addr = addr;
      s_instr = instr;
      s_pc = pc;
      chk("req", {31'b0, req}, {31'b0, e_req});
      chk("addr", addr, m_pc);
      chk("bubble", {31'b0, bub}, {31'b0, e_bub});
      chk("instr", instr, e_instr);
      chk("pc", pc, e_pc);
`ifdef FETCH_PERF_EN
      chk("perf", perf, m_perf[31:0]);
`endif
      @(posedge clk);
      empty0 = (pq.size() == 0);
      f = '{32'h0, 1'b1};
      if (rvalid) begin
         void'(mem.pop_front());
         f = infl.pop_front();
      end
      if (rd) begin
         pq.delete();
         foreach (infl[i]) infl[i].doomed = 1'b1;
         m_pc = {rp[31:2], 2'b00};
      end else begin
         if (!st && pq.size() > 0) void'(pq.pop_front());
         if (rvalid && !f.doomed) pq.push_back('{rdata, f.pc});
         if (e_req && g) begin
            infl.push_back('{m_pc, 1'b0});
            mem.push_back('{fix_data ? 32'h0050_0093 : $urandom,
                            cyc_n + 1 + int'($urandom_range(0, lat_max))});
            m_pc = m_pc + 32'd4;
         end
      end
      if (empty0 && !st && !rd && m_perf < 64'hFFFF_FFFF) m_perf++;
      cyc_n++;
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bit done;
      rst_n = 1'b0;
      stall = 1'b0;
      redirect = 1'b0;
      rpc = 32'h0;
      gnt = 1'b0;
      rvalid = 1'b0;
      rdata = 32'h0;

      // basic streaming, 1-cycle memory
      fix_data = 1'b1;
      lat_max = 0;
      do_reset();
      cyc(0, 0, 0, 1, 1);
      chk("t1_req0", {31'b0, s_req}, 32'd1);
      chk("t1_addr0", s_addr, 32'h0);
      chk("t1_bub0", {31'b0, s_bub}, 32'd1);
      cyc(0, 0, 0, 1, 1);
      chk("t1_addr1", s_addr, 32'h4);
      cyc(0, 0, 0, 1, 1);
      chk("t1_instr", s_instr, 32'h0050_0093);
      chk("t1_pc", s_pc, 32'h0);
      chk("t1_bub2", {31'b0, s_bub}, 32'd0);

      // grant withheld
      fix_data = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, 0, 1);
         chk("t2_req", {31'b0, s_req}, 32'd1);
         chk("t2_addr", s_addr, 32'h0);
         chk("t2_bub", {31'b0, s_bub}, 32'd1);
         chk("t2_instr", s_instr, 32'h13);
      end

      // stall with full queue
      do_reset();
      cyc(1, 0, 0, 1, 1);
      cyc(1, 0, 0, 1, 1);
      cyc(1, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 0, 1, 1);
         chk("t3_req", {31'b0, s_req}, 32'd0);
         chk("t3_pc", s_pc, 32'h0);
      end
      cyc(0, 0, 0, 0, 1);
      chk("t3_pop0", s_pc, 32'h0);
      cyc(0, 0, 0, 0, 1);
      chk("t3_pop1", s_pc, 32'h4);

      // redirect with two outstanding
      do_reset();
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 1, 32'h103, 1, 0);
      chk("t4_req_rd", {31'b0, s_req}, 32'd0);
      cyc(0, 0, 0, 1, 1);
      chk("t4_addr", s_addr, 32'h100);
      done = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
         cyc(0, 0, 0, 1, 1);
         if (!s_bub) done = 1'b1;
      end
      chk("t4_arrive", {31'b0, done}, 32'd1);
      chk("t4_pc", s_pc, 32'h100);

      // redirect coinciding with rvalid under stall
      do_reset();
      cyc(0, 0, 0, 1, 1);
      cyc(1, 1, 32'h200, 1, 1);
      chk("t5_req_rd", {31'b0, s_req}, 32'd0);
      cyc(1, 0, 0, 0, 1);
      chk("t5_bub", {31'b0, s_bub}, 32'd1);
      chk("t5_addr", s_addr, 32'h200);
      chk("t5_req", {31'b0, s_req}, 32'd1);

      // address wrap
      do_reset();
      cyc(0, 1, 32'hFFFF_FFFF, 0, 1);
      cyc(0, 0, 0, 1, 1);
      chk("t6_addr_top", s_addr, 32'hFFFF_FFFC);
      cyc(0, 0, 0, 0, 1);
      chk("t6_addr_wrap", s_addr, 32'h0);

`ifdef FETCH_PERF_EN
      do_reset();
      for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
      #1 chk("t6_perf10", perf, 32'd10);
`endif

      // randomized traffic with one mid-run reset
      lat_max = 3;
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if (i == 2000) do_reset();
         cyc($urandom_range(0, 9) < 3,
             $urandom_range(0, 19) == 0,
             $urandom,
             $urandom_range(0, 9) < 6,
             $urandom_range(0, 9) < 6);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
